// File: rtl/seg_display_scheduler_pkg.sv
// Shared FSM encoding, anode patterns and source tags for the 7-segment display scheduler.
// Pure declarations: no latency, no flow control.
// Consumers import with seg_display_scheduler_pkg::*.
package seg_display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHOW_WB  = 2'd1,
        ST_SHOW_DBG = 2'd2
    } state_t;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    localparam logic SRC_WB  = 1'b0;
    localparam logic SRC_DBG = 1'b1;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_DIG0;
            2'd1:    an = AN_DIG1;
            2'd2:    an = AN_DIG2;
            default: an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/digit_scan_timer.sv
// Free-running digit multiplexer: each digit is lit for REFRESH_DIV cycles, index wraps 3 -> 0.
// enable_o is registered and always matches idx_o in the same cycle.
// No backpressure: runs unconditionally, independent of what is being displayed.
module digit_scan_timer
    import seg_display_scheduler_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic [1:0] idx_o,
    output logic [3:0] enable_o
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    enable_q;

    always_comb begin
        div_d = div_q + DW'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Anode pattern is computed from the next index so it never lags idx_q.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q    <= '0;
            idx_q    <= 2'd0;
            enable_q <= AN_DIG0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            enable_q <= anode_for(idx_d);
        end
    end

    assign idx_o    = idx_q;
    assign enable_o = enable_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates writeback vs debug values onto a 4-digit display and holds each for HOLD_CYCLES.
// Latency: a latched value appears on shown_data/digit_nibble one cycle after acceptance.
// Writeback is never stalled; debug is backpressured via dbg_ready while a hold window runs.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int REFRESH_DIV = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        internal_clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [15:0] wb_data,
    input  logic        dbg_valid,
    input  logic [15:0] dbg_data,
    output logic        dbg_ready,
    output logic [15:0] shown_data,
    output logic        shown_src,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  enable,
    output logic        busy
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic [15:0]   shown_data_q;
    logic          shown_src_q;
    logic          busy_q;
    logic [1:0]    scan_idx;

    assign dbg_ready = (state_q == ST_IDLE) && !wb_valid;

    // Writeback preempts any state; only an idle display admits a debug value.
    always_ff @(posedge internal_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            shown_data_q <= 16'h0000;
            shown_src_q  <= SRC_WB;
            busy_q       <= 1'b0;
        end else if (wb_valid) begin
            state_q      <= ST_SHOW_WB;
            hold_q       <= HOLD_LAST;
            shown_data_q <= wb_data;
            shown_src_q  <= SRC_WB;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dbg_valid && dbg_ready) begin
                        state_q      <= ST_SHOW_DBG;
                        hold_q       <= HOLD_LAST;
                        shown_data_q <= dbg_data;
                        shown_src_q  <= SRC_DBG;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SHOW_WB, ST_SHOW_DBG: begin
                    if (hold_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    digit_scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk_i   (internal_clk),
        .reset_i (reset),
        .idx_o   (scan_idx),
        .enable_o(enable)
    );

    assign shown_data   = shown_data_q;
    assign shown_src    = shown_src_q;
    assign busy         = busy_q;
    assign digit_nibble = shown_data_q[{scan_idx, 2'b00} +: 4];

endmodule
